// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame checker.
//   rx_state_e : receive FSM states
//   rx_out_t   : registered payload beat presented on the RX_* outputs
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // Bytes held back so the trailing FCS never reaches the payload port.
    localparam int unsigned DLY_DEPTH = 5;
    localparam int unsigned FILL_W    = 3;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned CNT_W     = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       sof;
        logic       eof;
        logic       good;
        logic       bad;
    } rx_out_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected 0x04C11DB7) update for one byte, LSB first.
//   data      : input byte
//   crc_in    : current CRC register
//   crc_next_c: CRC register after absorbing data
module crc32_d8 (
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_next_c
);
    import gmii_rx_pkg::*;

    // Bit-serial update unrolled over the eight data bits.
    always_comb begin
        crc_next_c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_next_c[0] ^ data[i]) begin
                crc_next_c = (crc_next_c >> 1) ^ CRC_POLY;
            end else begin
                crc_next_c = crc_next_c >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD and FCS, checks CRC-32,
// length and RX_ER, and delivers the payload with SOF/EOF and good/bad status.
//   SGMII_CLK, RESET_N         : clock, async active-low reset
//   GMII_RX_CE                 : byte-sample enable
//   GMII_RXD/RX_DV/RX_ER       : GMII receive stream
//   RX_DATA/VALID/SOF/EOF      : payload byte stream (registered)
//   RX_GOOD/RX_BAD             : frame status, only with RX_EOF
//   FRAME_CNT_OK/FRAME_CNT_ERR : wrapping good / bad-or-aborted frame counters
module gmii_rx_frame_checker #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        SGMII_CLK,
    input  logic        RESET_N,
    input  logic        GMII_RX_CE,
    input  logic [7:0]  GMII_RXD,
    input  logic        GMII_RX_DV,
    input  logic        GMII_RX_ER,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    output logic        RX_SOF,
    output logic        RX_EOF,
    output logic        RX_GOOD,
    output logic        RX_BAD,
    output logic [15:0] FRAME_CNT_OK,
    output logic [15:0] FRAME_CNT_ERR
);
    import gmii_rx_pkg::*;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    rx_state_e                   state_q, state_d;
    logic [31:0]                 crc_q, crc_d, crc_next_c;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        err_q, err_d;
    logic [DLY_DEPTH-1:0][7:0]   dly_q, dly_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic                        sof_pend_q, sof_pend_d;
    logic [CNT_W-1:0]            cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0]            cnt_err_q, cnt_err_d;
    rx_out_t                     out_q, out_d;
    logic                        dly_full, len_ok, frame_ok;

    crc32_d8 u_crc (
        .data       (GMII_RXD),
        .crc_in     (crc_q),
        .crc_next_c (crc_next_c)
    );

    assign dly_full = (fill_q == FILL_W'(DLY_DEPTH));
    // A saturated length is always bad, whatever MAX_LEN is.
    assign len_ok   = (32'(len_q) >= MIN_LEN) && (32'(len_q) <= MAX_LEN) && (len_q != LEN_MAX);
    assign frame_ok = (crc_q == CRC_RESIDUE) && !err_q && len_ok;

    // State and datapath registers.
    always_ff @(posedge SGMII_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            err_q      <= 1'b0;
            dly_q      <= '0;
            fill_q     <= '0;
            sof_pend_q <= 1'b0;
            cnt_ok_q   <= '0;
            cnt_err_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            err_q      <= err_d;
            dly_q      <= dly_d;
            fill_q     <= fill_d;
            sof_pend_q <= sof_pend_d;
            cnt_ok_q   <= cnt_ok_d;
            cnt_err_q  <= cnt_err_d;
            out_q      <= out_d;
        end
    end

    // Next-state, datapath and output decode; only qualified samples advance.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        err_d      = err_q;
        dly_d      = dly_q;
        fill_d     = fill_q;
        sof_pend_d = sof_pend_q;
        cnt_ok_d   = cnt_ok_q;
        cnt_err_d  = cnt_err_q;
        out_d       = out_q;
        out_d.valid = 1'b0;
        out_d.sof   = 1'b0;
        out_d.eof   = 1'b0;
        out_d.good  = 1'b0;
        out_d.bad   = 1'b0;

        if (GMII_RX_CE) begin
            unique case (state_q)
                IDLE: begin
                    if (GMII_RX_DV) begin
                        state_d = (GMII_RXD == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!GMII_RX_DV) begin
                        state_d = IDLE;
                    end else if (GMII_RXD == SFD_BYTE) begin
                        state_d    = DATA;
                        crc_d      = CRC_INIT;
                        len_d      = '0;
                        err_d      = 1'b0;
                        fill_d     = '0;
                        sof_pend_d = 1'b1;
                    end else if (GMII_RXD != PREAMBLE_BYTE) begin
                        state_d = DROP;
                    end
                end
                DATA: begin
                    if (GMII_RX_DV) begin
                        crc_d = crc_next_c;
                        len_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
                        if (GMII_RX_ER) begin
                            err_d = 1'b1;
                        end
                        dly_d = {dly_q[DLY_DEPTH-2:0], GMII_RXD};
                        if (dly_full) begin
                            out_d.valid = 1'b1;
                            out_d.data  = dly_q[DLY_DEPTH-1];
                            out_d.sof   = sof_pend_q;
                            sof_pend_d  = 1'b0;
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end else begin
                        // End of frame: the four youngest bytes are the FCS.
                        state_d = IDLE;
                        fill_d  = '0;
                        if (dly_full) begin
                            out_d.valid = 1'b1;
                            out_d.data  = dly_q[DLY_DEPTH-1];
                            out_d.sof   = sof_pend_q;
                            out_d.eof   = 1'b1;
                            out_d.good  = frame_ok;
                            out_d.bad   = !frame_ok;
                            sof_pend_d  = 1'b0;
                            if (frame_ok) begin
                                cnt_ok_d = cnt_ok_q + CNT_W'(1);
                            end else begin
                                cnt_err_d = cnt_err_q + CNT_W'(1);
                            end
                        end else begin
                            cnt_err_d = cnt_err_q + CNT_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (!GMII_RX_DV) begin
                        state_d   = IDLE;
                        cnt_err_d = cnt_err_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign RX_DATA       = out_q.data;
    assign RX_VALID      = out_q.valid;
    assign RX_SOF        = out_q.sof;
    assign RX_EOF        = out_q.eof;
    assign RX_GOOD       = out_q.good;
    assign RX_BAD        = out_q.bad;
    assign FRAME_CNT_OK  = cnt_ok_q;
    assign FRAME_CNT_ERR = cnt_err_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Self-checking bench for gmii_rx_frame_checker: directed and randomized
// frames compared against a frame-level reference model.
module tb_gmii_rx_frame_checker;
    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1518;

    typedef logic [7:0] byte_q_t[$];

    logic        SGMII_CLK   = 1'b0;
    logic        RESET_N     = 1'b0;
    logic        GMII_RX_CE  = 1'b0;
    logic [7:0]  GMII_RXD    = 8'h00;
    logic        GMII_RX_DV  = 1'b0;
    logic        GMII_RX_ER  = 1'b0;
    logic [7:0]  RX_DATA;
    logic        RX_VALID, RX_SOF, RX_EOF, RX_GOOD, RX_BAD;
    logic [15:0] FRAME_CNT_OK, FRAME_CNT_ERR;

    int checks   = 0;
    int failures = 0;
    int exp_ok   = 0;
    int exp_err  = 0;

    logic [7:0] cap_data[$];
    logic       cap_sof[$];
    logic       cap_eof[$];
    int eof_total  = 0;
    int good_total = 0;
    int bad_total  = 0;
    int viol       = 0;

    gmii_rx_frame_checker #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .SGMII_CLK     (SGMII_CLK),
        .RESET_N       (RESET_N),
        .GMII_RX_CE    (GMII_RX_CE),
        .GMII_RXD      (GMII_RXD),
        .GMII_RX_DV    (GMII_RX_DV),
        .GMII_RX_ER    (GMII_RX_ER),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_SOF        (RX_SOF),
        .RX_EOF        (RX_EOF),
        .RX_GOOD       (RX_GOOD),
        .RX_BAD        (RX_BAD),
        .FRAME_CNT_OK  (FRAME_CNT_OK),
        .FRAME_CNT_ERR (FRAME_CNT_ERR)
    );

    always #4 SGMII_CLK = ~SGMII_CLK;

    // Output monitor on the inactive edge: records every payload beat and
    // counts status flags seen outside a valid EOF beat.
    always @(negedge SGMII_CLK) begin
        if (RX_VALID === 1'b1) begin
            cap_data.push_back(RX_DATA);
            cap_sof.push_back(RX_SOF);
            cap_eof.push_back(RX_EOF);
        end
        eof_total  <= eof_total  + ((RX_VALID && RX_EOF) ? 1 : 0);
        good_total <= good_total + ((RX_VALID && RX_EOF && RX_GOOD) ? 1 : 0);
        bad_total  <= bad_total  + ((RX_VALID && RX_EOF && RX_BAD) ? 1 : 0);
        viol <= viol
              + (((RX_GOOD || RX_BAD) && !(RX_VALID && RX_EOF)) ? 1 : 0)
              + ((RX_GOOD && RX_BAD) ? 1 : 0)
              + ((!RX_VALID && (RX_SOF || RX_EOF)) ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Standard Ethernet FCS value (inverted CRC-32) of a byte sequence.
    function automatic logic [31:0] fcs_of(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic byte_q_t make_payload(input int len, input bit rnd);
        byte_q_t q;
        for (int i = 0; i < len; i++) begin
            q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
        end
        return q;
    endfunction

    task automatic put(input logic dv, input logic [7:0] d, input logic er, input int pace);
        for (int i = 0; i < pace; i++) begin
            GMII_RX_CE = (i == 0);
            GMII_RX_DV = dv;
            GMII_RXD   = d;
            GMII_RX_ER = er;
            @(posedge SGMII_CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 8'h00, 1'b0, 1);
    endtask

    // Sends one frame and checks delivery, status and counters against the model.
    task automatic run_frame(input string tag, input int pre_n, input byte_q_t payload,
                             input bit corrupt, input int er_idx, input int pace);
        byte_q_t     f;
        byte_q_t     body;
        logic [31:0] fcs, rx_fcs;
        int          n, base, eof0, good0, bad0, mism, sof_sum, eof_sum, exp_n;
        bit          emit, good;

        f   = payload;
        fcs = fcs_of(payload);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        if (corrupt) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
        n = f.size();

        emit  = (n >= 5);
        good  = 1'b0;
        exp_n = emit ? n - 4 : 0;
        if (emit) begin
            body   = f[0:n-5];
            rx_fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
            good   = (fcs_of(body) == rx_fcs) && (er_idx < 0) &&
                     (n >= int'(MIN_LEN)) && (n <= int'(MAX_LEN));
        end
        if (good) exp_ok++; else exp_err++;

        base  = cap_data.size();
        eof0  = eof_total;
        good0 = good_total;
        bad0  = bad_total;

        for (int i = 0; i < pre_n; i++) put(1'b1, 8'h55, 1'b0, pace);
        put(1'b1, 8'hD5, 1'b0, pace);
        for (int i = 0; i < n; i++) put(1'b1, f[i], (i == er_idx), pace);
        put(1'b0, 8'h00, 1'b0, pace);
        idle(2 + int'($urandom_range(0, 4)));

        mism = 0;
        for (int i = 0; i < exp_n; i++) begin
            if ((base + i) >= cap_data.size() || cap_data[base+i] !== f[i]) mism++;
        end
        sof_sum = 0;
        eof_sum = 0;
        for (int i = base; i < cap_sof.size(); i++) begin
            sof_sum += (cap_sof[i] === 1'b1) ? 1 : 0;
            eof_sum += (cap_eof[i] === 1'b1) ? 1 : 0;
        end

        check({tag, " nvalid"}, cap_data.size() - base, exp_n);
        check({tag, " data"}, mism, 0);
        check({tag, " sof_cnt"}, sof_sum, emit ? 1 : 0);
        check({tag, " eof_flag_cnt"}, eof_sum, emit ? 1 : 0);
        if (emit && cap_data.size() > base) begin
            check({tag, " sof_first_eof_last"}, {30'h0, cap_sof[base], cap_eof[cap_eof.size()-1]}, 2'b11);
        end
        check({tag, " eof_events"}, eof_total - eof0, emit ? 1 : 0);
        check({tag, " good"}, good_total - good0, (emit && good) ? 1 : 0);
        check({tag, " bad"}, bad_total - bad0, (emit && !good) ? 1 : 0);
        check({tag, " cnt_ok"}, FRAME_CNT_OK, exp_ok);
        check({tag, " cnt_err"}, FRAME_CNT_ERR, exp_err);
    endtask

    initial begin
        byte_q_t pl;
        byte_q_t f;
        logic [31:0] fcs;
        int base, eof0, len, pace, er, pre;
        bit corrupt;

        repeat (4) @(posedge SGMII_CLK);
        #1;
        check("reset_flags", {19'h0, RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_GOOD, RX_BAD}, 0);
        check("reset_cnt", {FRAME_CNT_OK, FRAME_CNT_ERR}, 0);
        RESET_N = 1'b1;
        idle(4);

        pl = make_payload(60, 1'b0);
        run_frame("good64", 7, pl, 1'b0, -1, 1);
        run_frame("bad_fcs", 7, pl, 1'b1, -1, 1);
        run_frame("rx_er", 7, pl, 1'b0, 10, 1);
        pl = make_payload(36, 1'b1);
        run_frame("runt40", 7, pl, 1'b0, -1, 1);
        pl = make_payload(59, 1'b1);
        run_frame("len63", 3, pl, 1'b0, -1, 1);
        pl = make_payload(1515, 1'b1);
        run_frame("len1519", 7, pl, 1'b0, -1, 1);
        pl = make_payload(1514, 1'b1);
        run_frame("len1518", 7, pl, 1'b0, -1, 1);
        pl = make_payload(1, 1'b1);
        run_frame("single_byte", 2, pl, 1'b0, -1, 1);
        pl = make_payload(0, 1'b1);
        run_frame("short4", 7, pl, 1'b0, -1, 1);

        // DV rises on a non-preamble byte: whole frame dropped, counted once.
        base = cap_data.size();
        put(1'b1, 8'hAA, 1'b0, 1);
        repeat (3) put(1'b1, 8'h55, 1'b0, 1);
        put(1'b1, 8'hD5, 1'b0, 1);
        for (int i = 0; i < 10; i++) put(1'b1, 8'(i), 1'b0, 1);
        put(1'b0, 8'h00, 1'b0, 1);
        idle(4);
        exp_err++;
        check("malformed nvalid", cap_data.size() - base, 0);
        check("malformed cnt_err", FRAME_CNT_ERR, exp_err);
        check("malformed cnt_ok", FRAME_CNT_OK, exp_ok);

        // Preamble that ends without SFD is not counted.
        repeat (5) put(1'b1, 8'h55, 1'b0, 1);
        put(1'b0, 8'h00, 1'b0, 1);
        idle(4);
        check("pre_only cnt_err", FRAME_CNT_ERR, exp_err);
        check("pre_only cnt_ok", FRAME_CNT_OK, exp_ok);

        pl = make_payload(60, 1'b1);
        run_frame("paced100m", 7, pl, 1'b0, -1, 10);

        for (int r = 0; r < 8; r++) begin
            len     = int'($urandom_range(0, 90));
            pace    = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(1, 2));
            corrupt = ($urandom_range(0, 3) == 0);
            er      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len + 3)) : -1;
            pre     = int'($urandom_range(1, 7));
            pl      = make_payload(len, 1'b1);
            run_frame("rand", pre, pl, corrupt, er, pace);
        end

        // Reset in the middle of payload byte 20, released with DV still high.
        pl  = make_payload(60, 1'b0);
        f   = pl;
        fcs = fcs_of(pl);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        base = cap_data.size();
        eof0 = eof_total;
        repeat (7) put(1'b1, 8'h55, 1'b0, 1);
        put(1'b1, 8'hD5, 1'b0, 1);
        for (int i = 0; i < 20; i++) put(1'b1, f[i], 1'b0, 1);
        RESET_N = 1'b0;
        put(1'b1, f[20], 1'b0, 1);
        check("midrst_flags", {19'h0, RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_GOOD, RX_BAD}, 0);
        check("midrst_cnt", {FRAME_CNT_OK, FRAME_CNT_ERR}, 0);
        put(1'b1, f[21], 1'b0, 1);
        put(1'b1, f[22], 1'b0, 1);
        RESET_N = 1'b1;
        for (int i = 23; i < f.size(); i++) put(1'b1, f[i], 1'b0, 1);
        put(1'b0, 8'h00, 1'b0, 1);
        idle(4);
        exp_ok  = 0;
        exp_err = 1;
        check("midrst nvalid", cap_data.size() - base, 14);
        check("midrst eof", eof_total - eof0, 0);
        check("midrst cnt_ok", FRAME_CNT_OK, exp_ok);
        check("midrst cnt_err", FRAME_CNT_ERR, exp_err);

        check("status_protocol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame_checker.md
Name: gmii_rx_frame_checker

Overview:
- Consumes the GMII receive stream from the gigabit PCS/PMA wrapper (GMII_RXD/RX_DV/RX_ER) on the SGMII_CLK domain.
- Strips the preamble and SFD, strips and checks the FCS (CRC-32), and delivers a payload byte stream with SOF/EOF and good/bad status.
- Keeps good-frame and bad-frame counters for link diagnostics.
- Sits between the PCS/PMA wrapper and the TCP/IP receive logic.

Parameters:
- MIN_LEN, 64, minimum legal length in bytes, counted after SFD and including FCS; shorter frames are runts and flagged bad.
- MAX_LEN, 1518, maximum legal length, same counting; longer frames are flagged bad.

Ports:
- SGMII_CLK  in  1  125 MHz GMII clock; all logic is on this clock.
- RESET_N  in  1  asynchronous active-low reset.
- GMII_RX_CE  in  1  byte-sample enable: 1 every cycle at 1 Gb/s, 1 in 10 or 1 in 100 at 100/10 Mb/s.
- GMII_RXD  in  8  receive data.
- GMII_RX_DV  in  1  receive data valid.
- GMII_RX_ER  in  1  receive error.
- RX_DATA  out  8  payload byte.
- RX_VALID  out  1  RX_DATA is valid this cycle.
- RX_SOF  out  1  first payload byte; qualified by RX_VALID.
- RX_EOF  out  1  last payload byte; qualified by RX_VALID.
- RX_GOOD  out  1  frame OK; asserted only with RX_EOF.
- RX_BAD  out  1  frame bad; asserted only with RX_EOF, exclusive with RX_GOOD.
- FRAME_CNT_OK  out  16  count of good frames, wraps at 0xFFFF.
- FRAME_CNT_ERR  out  16  count of bad or aborted frames, wraps at 0xFFFF.

Behaviour:
- Reset: all outputs 0, state IDLE, delay line empty, CRC = 0xFFFFFFFF.
- Input qualification: inputs are sampled only when GMII_RX_CE=1. With CE=0, state, CRC and counters hold, and RX_VALID, RX_SOF, RX_EOF, RX_GOOD and RX_BAD are 0.
- IDLE:
  - DV=1 and RXD=0x55 -> PREAMBLE.
  - DV=1 with any other RXD -> DROP.
  - DV=0 -> stay.
- PREAMBLE:
  - RXD=0x55 -> stay; any count of 0x55 is accepted.
  - RXD=0xD5 -> DATA; CRC seeded to 0xFFFFFFFF, length = 0.
  - Any other byte -> DROP.
  - DV=0 -> IDLE; not counted.
- DATA:
  - Each qualified byte updates the CRC (reflected 0x04C11DB7, LSB first), increments the 16-bit saturating length, and shifts into a 5-byte delay line.
  - A byte is emitted when a 5th byte enters behind it. The first emission has RX_SOF=1.
  - Latency from GMII byte to RX_DATA is 5 qualified samples plus 1 register cycle.
  - RX_ER=1 sets a sticky error flag for the frame.
- DATA end (DV=0 on a qualified sample):
  - The oldest delay-line byte is emitted with RX_EOF=1; the remaining 4 bytes (the FCS) are discarded.
  - RX_GOOD=1 only if: CRC register equals residue 0xDEBB20E3 (the reflected, pre-inversion form of residue 0xC704DD7B), no error flag, and MIN_LEN ≤ length ≤ MAX_LEN. Otherwise RX_BAD=1.
  - The matching counter increments in the same cycle. State -> IDLE.
- Short frames: if DV falls with fewer than 5 bytes after SFD, nothing is emitted (no SOF/EOF), FRAME_CNT_ERR increments, state -> IDLE.
- DROP: ignore bytes until DV=0 on a qualified sample, then -> IDLE. FRAME_CNT_ERR increments once.
- Length saturation: the length saturates at 0xFFFF; the frame is still delivered and flagged bad.
- Reset mid-frame: output stops immediately and no EOF is produced. After release with DV still high, the first non-0x55 byte drives IDLE -> DROP.
- Single-byte frames: RX_SOF and RX_EOF may both be 1 on the same byte. This only occurs when exactly 5 bytes follow the SFD.

Decomposition:
- Package gmii_rx_pkg:
  - state enum {IDLE, PREAMBLE, DATA, DROP};
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320 (reflected), CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3.
- Sub-module crc32_d8: combinational next-CRC from 8-bit data and 32-bit current CRC. It is instantiated once; the state register stays in the parent.

Test Plan:
- Good frame: 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS, CE=1 -> 60 bytes out; SOF on 0x00, EOF+GOOD on 0x3B; FRAME_CNT_OK=1.
- Corrupted FCS: same frame with the last FCS byte XOR 0x01 -> payload still delivered, EOF with RX_BAD=1; FRAME_CNT_ERR=1, FRAME_CNT_OK unchanged.
- Errors and runts:
  - RX_ER pulsed for 1 cycle on payload byte 10 -> RX_BAD at EOF.
  - 40-byte runt with valid FCS -> RX_BAD.
  - 1519-byte frame with valid FCS -> RX_BAD.
- Malformed preamble: DV rises with RXD=0xAA -> no RX_VALID for the whole frame; FRAME_CNT_ERR +1 at DV fall. DV drops after 0x55 bytes only -> no counter change.
- 100 Mb/s pacing: CE high 1 in 10 cycles, each byte held 10 cycles, good 64-byte frame -> exactly 60 RX_VALID pulses (one per CE), GOOD at EOF.
- Reset mid-frame: assert RESET_N=0 at payload byte 20 and release with DV still high -> all outputs 0, counters 0; the frame remainder is dropped; FRAME_CNT_ERR=1 after DV falls.
